ahbl_dma_initiator: RTL and testbench
=====================================

// Module: ahbl_dma_initiator
// PURPOSE
//  AHB-Lite initiator (bus master) for word-granular memory-to-memory copies, e.g. USB CDC FIFO -> SRAM.
//  Drives a splitter source port. Same signal set as the responders, opposite direction.
//  Single-beat, non-overlapped transfers: each word is one read followed by one write.
// PARAMETERS
//  W_ADDR  32  address width
//  W_DATA  32  data width; only 32 is supported
//  W_LEN   16  width of the word-count register
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       synchronous, active-low reset
//  cfg_src    in   W_ADDR  source byte address; bits[1:0] ignored
//  cfg_dst    in   W_ADDR  destination byte address; bits[1:0] ignored
//  cfg_len    in   W_LEN   number of 32-bit words to copy
//  start      in   1       1-cycle pulse; sampled only when busy=0
//  busy       out  1       transfer in progress
//  done       out  1       1-cycle pulse at end of transfer (success or error)
//  err        out  1       sticky; set on hresp, cleared by the next accepted start
//  hready     in   1       bus ready (HREADY from the splitter)
//  hresp      in   1       bus error response
//  haddr      out  W_ADDR  address
//  hwrite     out  1       1=write
//  htrans     out  2       IDLE(00) or NONSEQ(10) only
//  hsize      out  3       always 3'b010 (word)
//  hburst     out  3       always 3'b000 (SINGLE)
//  hprot      out  4       always 4'b0011
//  hmastlock  out  1       always 0
//  hwdata     out  W_DATA  write data (data phase)
//  hrdata     in   W_DATA  read data
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE; busy=0, done=0, err=0; htrans=IDLE, haddr=0, hwrite=0, hwdata=0.
//   - Reset mid-transfer abandons the copy immediately; no done pulse.
//  FSM states: IDLE, RD_A, RD_D, WR_A, WR_D, FIN.
//   - IDLE: start & cfg_len!=0 -> latch src/dst (low bits forced 00) and len, clear err, go to RD_A.
//   - IDLE: start & cfg_len==0 -> go to FIN with no bus traffic (done appears 1 cycle after start).
//   - RD_A: htrans=NONSEQ, hwrite=0, haddr=src. On hready -> RD_D.
//   - RD_D: htrans=IDLE. On hready & !hresp -> buf<=hrdata, go to WR_A.
//   - WR_A: htrans=NONSEQ, hwrite=1, haddr=dst. On hready -> WR_D.
//   - WR_D: htrans=IDLE, hwdata=buf (held stable until hready). On hready & !hresp:
//     src+=4, dst+=4, len-=1; if the new len==0 go to FIN, else go to RD_A.
//   - Error: hresp=1 in RD_D/WR_D sets err. Wait for hready (end of the 2-cycle error
//     response), then go to FIN. No further NONSEQ is issued.
//   - FIN: done=1 for exactly one cycle, then IDLE. busy=1 in every state except IDLE.
//  Address phase control outputs are held stable while hready=0.
//  Steady state: 4 clk per word with zero-wait responders; N words -> done at 4N+1 cycles after start.
//  Address arithmetic is modulo 2^W_ADDR and wraps silently. The copy never crosses into a new transfer.
//  start while busy=1 is ignored; cfg_* are sampled only at an accepted start.
// CONFIGURATION
//  AHBL_DMA_FILL_EN defined:
//   - Adds input cfg_fill (1) and input cfg_pattern (W_DATA).
//   - If cfg_fill=1 at start: RD_A/RD_D are skipped, buf<=cfg_pattern, and each word takes 2 clk.
//  AHBL_DMA_FILL_EN undefined: those ports do not exist; copy-only.
// STRUCTURE
//  Shared include ahbl_defs.vh holds:
//   - HTRANS_IDLE / HTRANS_NONSEQ, HSIZE_WORD, HBURST_SINGLE, HPROT_DATA_PRIV.
//   - FSM state encodings for this module.
//  Single module, no sub-module; the counter and address incrementers are inline.
// TESTING
//  - src=0x4800_0000, dst=0x4800_0100, len=3, zero-wait SRAM -> 3 words copied; done at cycle 13; err=0.
//  - len=0 -> no NONSEQ seen; done 1 cycle after start; busy high for exactly 1 cycle.
//  - Responder inserts 2 wait states per data phase -> haddr, htrans, hwdata stable while hready=0;
//    data copied correctly.
//  - hresp=1 on the 2nd read -> err=1; 1 word written; no NONSEQ after the error; done pulses.
//  - src=0xFFFF_FFFC, len=2 -> 2nd read address is 0x0000_0000 (wrap).
//  - FILL_EN: cfg_fill=1, pattern=0xA5A5_A5A5, len=4 -> 4 writes only; done at cycle 9.

Source files
------------

// File: rtl/ahbl_dma_initiator_pkg.sv
// Shared constants for the AHB-Lite DMA initiator: bus encodings and FSM state codes.
package ahbl_dma_initiator_pkg;

    typedef logic [1:0] htrans_t;

    localparam htrans_t    HTRANS_IDLE     = 2'b00;
    localparam htrans_t    HTRANS_NONSEQ   = 2'b10;
    localparam logic [2:0] HSIZE_WORD      = 3'b010;
    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    // state   | meaning
    // IDLE    | waiting for start
    // RD_A    | read address phase (NONSEQ, hwrite=0, haddr=src)
    // RD_D    | read data phase, capture hrdata
    // WR_A    | write address phase (NONSEQ, hwrite=1, haddr=dst)
    // WR_D    | write data phase, hwdata held from the word buffer
    // FIN     | one-cycle done pulse
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD_A = 3'd1;
    localparam logic [2:0] ST_RD_D = 3'd2;
    localparam logic [2:0] ST_WR_A = 3'd3;
    localparam logic [2:0] ST_WR_D = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

endpackage

// File: rtl/ahbl_dma_initiator_if.sv
// AHB-Lite bus bundle between the DMA initiator (master) and a responder/splitter port (slave).
interface ahbl_dma_initiator_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
    logic [W_DATA-1:0] hwdata;
    logic [W_DATA-1:0] hrdata;
    logic              hready;
    logic              hresp;

    modport master (
        output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/ahbl_dma_initiator.sv
// AHB-Lite DMA initiator: word-granular memory-to-memory copy, one read then one write per word,
// single-beat and non-overlapped. Optional fill mode (write a constant pattern, no reads) is
// enabled by defining AHBL_DMA_FILL_EN.
module ahbl_dma_initiator
    import ahbl_dma_initiator_pkg::*;
#(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32,
    parameter int W_LEN  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_ADDR-1:0] cfg_src,
    input  logic [W_ADDR-1:0] cfg_dst,
    input  logic [W_LEN-1:0]  cfg_len,
`ifdef AHBL_DMA_FILL_EN
    input  logic              cfg_fill,
    input  logic [W_DATA-1:0] cfg_pattern,
`endif
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    ahbl_dma_initiator_if.master bus
);

    logic [2:0]        state_q;
    logic [W_ADDR-1:0] src_q;
    logic [W_ADDR-1:0] dst_q;
    logic [W_LEN-1:0]  len_q;
    logic [W_DATA-1:0] data_q;
    logic              err_q;
    logic              fill_q;

    logic              fill_req;
    logic [W_DATA-1:0] pattern;

`ifdef AHBL_DMA_FILL_EN
    assign fill_req = cfg_fill;
    assign pattern  = cfg_pattern;
`else
    assign fill_req = 1'b0;
    assign pattern  = '0;
`endif

    // Sequencer: accepts a job in IDLE, walks read/write phases per word, ends in FIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        if (cfg_len != '0) begin
                            src_q  <= cfg_src & ~W_ADDR'(3);
                            dst_q  <= cfg_dst & ~W_ADDR'(3);
                            len_q  <= cfg_len;
                            fill_q <= fill_req;
                            if (fill_req) begin
                                data_q  <= pattern;
                                state_q <= ST_WR_A;
                            end else begin
                                state_q <= ST_RD_A;
                            end
                        end else begin
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_RD_A: begin
                    if (bus.hready) state_q <= ST_RD_D;
                end
                ST_RD_D: begin
                    // hresp rises one cycle before the terminating hready of an error response
                    if (bus.hresp) err_q <= 1'b1;
                    if (bus.hready) begin
                        if (bus.hresp) begin
                            state_q <= ST_FIN;
                        end else begin
                            data_q  <= bus.hrdata;
                            state_q <= ST_WR_A;
                        end
                    end
                end
                ST_WR_A: begin
                    if (bus.hready) state_q <= ST_WR_D;
                end
                ST_WR_D: begin
                    if (bus.hresp) err_q <= 1'b1;
                    if (bus.hready) begin
                        if (bus.hresp) begin
                            state_q <= ST_FIN;
                        end else begin
                            src_q <= src_q + W_ADDR'(4);
                            dst_q <= dst_q + W_ADDR'(4);
                            len_q <= len_q - W_LEN'(1);
                            if (len_q == W_LEN'(1)) state_q <= ST_FIN;
                            else if (fill_q)         state_q <= ST_WR_A;
                            else                     state_q <= ST_RD_A;
                        end
                    end
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Bus outputs decode purely from registered state, so they hold while hready is low.
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_FIN);
        err  = err_q;

        bus.htrans    = ((state_q == ST_RD_A) || (state_q == ST_WR_A)) ? HTRANS_NONSEQ : HTRANS_IDLE;
        bus.hwrite    = (state_q == ST_WR_A);
        bus.haddr     = ((state_q == ST_WR_A) || (state_q == ST_WR_D)) ? dst_q : src_q;
        bus.hwdata    = data_q;
        bus.hsize     = HSIZE_WORD;
        bus.hburst    = HBURST_SINGLE;
        bus.hprot     = HPROT_DATA_PRIV;
        bus.hmastlock = 1'b0;
    end

endmodule

// File: tb/tb_ahbl_dma_initiator.sv
// Bench for ahbl_dma_initiator: a behavioural AHB-Lite memory responder with optional wait
// states and error injection, plus a transfer-list reference model built from the copy rules.
module tb_ahbl_dma_initiator;
    import ahbl_dma_initiator_pkg::*;

    localparam int W_ADDR = 32;
    localparam int W_DATA = 32;
    localparam int W_LEN  = 16;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [W_ADDR-1:0] cfg_src = '0;
    logic [W_ADDR-1:0] cfg_dst = '0;
    logic [W_LEN-1:0]  cfg_len = '0;
`ifdef AHBL_DMA_FILL_EN
    logic              cfg_fill = 1'b0;
    logic [W_DATA-1:0] cfg_pattern = '0;
`endif
    logic              start = 1'b0;
    logic              busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    ahbl_dma_initiator_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

    ahbl_dma_initiator #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_LEN(W_LEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_src     (cfg_src),
        .cfg_dst     (cfg_dst),
        .cfg_len     (cfg_len),
`ifdef AHBL_DMA_FILL_EN
        .cfg_fill    (cfg_fill),
        .cfg_pattern (cfg_pattern),
`endif
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sparse memory; unwritten words return an address-derived value.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    // Responder configuration and observed transfer trace.
    int    max_wait  = 0;
    bit    fixed_w   = 1'b0;
    int    err_at    = -1;
    int    xfer_idx  = 0;
    xfer_t obs_q[$];

    bit          dp_active = 1'b0;
    bit          dp_write  = 1'b0;
    bit          dp_err    = 1'b0;
    logic [31:0] dp_addr   = '0;
    int          dp_cnt    = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] s_haddr, s_hwdata;
    logic [1:0]  s_htrans;
    logic        s_hwrite;

    initial begin
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        bus.hrdata = '0;
    end

    // Responder: decides hready/hresp/hrdata for the coming edge, logs completed transfers.
    always @(negedge clk) begin
        bit    completing;
        xfer_t rec;
        if (!rst_n) begin
            dp_active  = 1'b0;
            prev_stall = 1'b0;
            bus.hready = 1'b1;
            bus.hresp  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stable_haddr",  bus.haddr,  s_haddr);
                check("stable_htrans", bus.htrans, s_htrans);
                check("stable_hwrite", bus.hwrite, s_hwrite);
                check("stable_hwdata", bus.hwdata, s_hwdata);
            end
            completing = 1'b0;
            if (dp_active && dp_cnt > 0) begin
                bus.hready = 1'b0;
                bus.hresp  = dp_err && (dp_cnt == 1);
                dp_cnt--;
            end else begin
                bus.hready = 1'b1;
                bus.hresp  = dp_active && dp_err;
                completing = dp_active;
            end
            bus.hrdata = $urandom;
            if (completing) begin
                rec.wr   = dp_write;
                rec.addr = dp_addr;
                rec.data = '0;
                if (!dp_err) begin
                    if (dp_write) begin
                        rec.data      = bus.hwdata;
                        mem[dp_addr]  = bus.hwdata;
                    end else begin
                        bus.hrdata = rd_mem(dp_addr);
                        rec.data   = bus.hrdata;
                    end
                end
                obs_q.push_back(rec);
                dp_active = 1'b0;
            end
            if (bus.hready && bus.htrans == HTRANS_NONSEQ) begin
                check("hsize_word", {bus.hsize, bus.hburst, bus.hprot, bus.hmastlock},
                      {3'b010, 3'b000, 4'b0011, 1'b0});
                dp_active = 1'b1;
                dp_write  = bus.hwrite;
                dp_addr   = bus.haddr;
                dp_err    = (xfer_idx == err_at);
                dp_cnt    = (fixed_w ? max_wait : int'($urandom_range(0, max_wait))) + (dp_err ? 1 : 0);
                xfer_idx++;
            end
            prev_stall = !bus.hready;
            s_haddr  = bus.haddr;
            s_htrans = bus.htrans;
            s_hwrite = bus.hwrite;
            s_hwdata = bus.hwdata;
        end
    end

    // One job: build the expected transfer list, run the DUT, compare timing, trace and err.
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input bit fill, input logic [31:0] pat, input int mw, input bit fw,
                            input int ea, input bit poke_busy);
        xfer_t       exp_q[$];
        xfer_t       e;
        logic [31:0] s, d;
        int          idx, n, busy_cycles, exp_lat;
        bit          stop, got;

        @(negedge clk);
        obs_q.delete();
        xfer_idx = 0;
        max_wait = mw;
        fixed_w  = fw;
        err_at   = ea;

        s = src & ~32'd3;
        d = dst & ~32'd3;
        idx = 0;
        stop = 1'b0;
        for (int k = 0; k < len && !stop; k++) begin
            if (!fill) begin
                e = '{1'b0, s, (idx == ea) ? 32'h0 : rd_mem(s)};
                exp_q.push_back(e);
                if (idx == ea) stop = 1'b1;
                idx++;
            end
            if (!stop) begin
                e = '{1'b1, d, (idx == ea) ? 32'h0 : (fill ? pat : rd_mem(s))};
                exp_q.push_back(e);
                if (idx == ea) stop = 1'b1;
                idx++;
            end
            s = s + 32'd4;
            d = d + 32'd4;
        end

        cfg_src = src;
        cfg_dst = dst;
        cfg_len = W_LEN'(len);
`ifdef AHBL_DMA_FILL_EN
        cfg_fill    = fill;
        cfg_pattern = pat;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        busy_cycles = 0;
        got = 1'b0;
        while (n <= 2000) begin
            if (n == 1) check("err_cleared_at_start", err, 1'b0);
            if (poke_busy && n == 2) begin
                cfg_src = 32'hDEAD_0000;
                cfg_len = W_LEN'(7);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cycles++;
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("done_seen", got, 1'b1);
        if (mw == 0 && !stop) begin
            exp_lat = fill ? 2 * len + 1 : 4 * len + 1;
            check("done_latency", n, exp_lat);
            check("busy_cycles", busy_cycles, exp_lat);
        end
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("busy_after_done", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("xfer_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check("xfer_dir",  obs_q[i].wr,   exp_q[i].wr);
            check("xfer_addr", obs_q[i].addr, exp_q[i].addr);
            check("xfer_data", obs_q[i].data, exp_q[i].data);
        end
        check("err_flag", err, stop);
    endtask

    initial begin
        int wr_cnt;
        int len, mw, ea;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   busy,       1'b0);
        check("rst_done",   done,       1'b0);
        check("rst_err",    err,        1'b0);
        check("rst_htrans", bus.htrans, HTRANS_IDLE);
        check("rst_haddr",  bus.haddr,  32'h0);
        check("rst_hwrite", bus.hwrite, 1'b0);
        check("rst_hwdata", bus.hwdata, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 3-word copy, zero-wait
        run_copy(32'h4800_0000, 32'h4800_0100, 3, 1'b0, 32'h0, 0, 1'b0, -1, 1'b0);

        // Zero-length job
        run_copy(32'h1000_0040, 32'h2000_0040, 0, 1'b0, 32'h0, 0, 1'b0, -1, 1'b0);

        // Two wait states on every data phase
        run_copy(32'h1000_0203, 32'h2000_0301, 3, 1'b0, 32'h0, 2, 1'b1, -1, 1'b0);

        // Error on the second read
        run_copy(32'h1000_0400, 32'h2000_0400, 3, 1'b0, 32'h0, 0, 1'b0, 2, 1'b0);
        wr_cnt = 0;
        foreach (obs_q[i]) if (obs_q[i].wr) wr_cnt++;
        check("err_one_write", wr_cnt, 1);
        check("err_sticky", err, 1'b1);

        // Address wrap
        run_copy(32'hFFFF_FFFC, 32'h3000_0000, 2, 1'b0, 32'h0, 0, 1'b0, -1, 1'b0);
        if (obs_q.size() > 2) check("wrap_addr", obs_q[2].addr, 32'h0);
        else check("wrap_xfers", obs_q.size(), 3);

        // Start while busy is ignored
        run_copy(32'h1000_0800, 32'h2000_0800, 2, 1'b0, 32'h0, 0, 1'b0, -1, 1'b1);

        // Randomized jobs
        for (int t = 0; t < 10; t++) begin
            len = int'($urandom_range(1, 5));
            mw  = int'($urandom_range(0, 2));
            ea  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2 * len - 1)) : -1;
            run_copy(32'h1000_0000 | 32'($urandom_range(0, 16'hFFFF)),
                     32'h2000_0000 | 32'($urandom_range(0, 16'hFFFF)),
                     len, 1'b0, 32'h0, mw, 1'b0, ea, $urandom_range(0, 1) == 1);
        end

`ifdef AHBL_DMA_FILL_EN
        run_copy(32'h1000_1000, 32'h2000_1000, 4, 1'b1, 32'hA5A5_A5A5, 0, 1'b0, -1, 1'b0);
        run_copy(32'h1000_1100, 32'h2000_1100, 3, 1'b1, 32'h1234_5678, 2, 1'b0, -1, 1'b0);
`endif

        // Reset in the middle of a copy: no done, outputs return to reset values
        @(negedge clk);
        err_at   = -1;
        max_wait = 0;
        cfg_src  = 32'h1000_2000;
        cfg_dst  = 32'h2000_2000;
        cfg_len  = W_LEN'(5);
`ifdef AHBL_DMA_FILL_EN
        cfg_fill = 1'b0;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy_before_rst", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy",   busy,       1'b0);
        check("mid_rst_done",   done,       1'b0);
        check("mid_rst_htrans", bus.htrans, HTRANS_IDLE);
        check("mid_rst_haddr",  bus.haddr,  32'h0);
        check("mid_rst_hwdata", bus.hwdata, 32'h0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_done", done, 1'b0);
        end

        // Copy again after the abandoned job
        run_copy(32'h1000_3000, 32'h2000_3000, 2, 1'b0, 32'h0, 0, 1'b0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
